// File: rtl/ins_loader.sv
// Boot-time instruction loader: receives a length-prefixed byte stream and writes
// big-endian 32-bit words to instruction memory, holding the core until finished.
module ins_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_count;
  logic [15:0] r_idx;
  logic [1:0]  r_bcnt;
  logic [31:0] r_asm;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;

  logic        w_xfer;
  logic [15:0] w_hdr_n;
  logic        w_hdr_bad;
  logic [15:0] w_idx_inc;
  logic        w_last;
  logic [31:0] w_word;

  assign w_xfer    = rx_valid && rx_ready;
  assign w_hdr_n   = {r_count[15:8], rx_byte};
  assign w_hdr_bad = (w_hdr_n == '0) || (32'(w_hdr_n) > 32'(MAX_WORDS));
  assign w_idx_inc = r_idx + 16'd1;
  assign w_last    = (w_idx_inc == r_count);
  assign w_word    = {r_asm[23:0], rx_byte};

  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    rx_ready  = 1'b0;
    wr_en     = 1'b0;
    core_hold = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_HDR_HI;
      end
      S_HDR_HI: begin
        rx_ready = 1'b1;
        if (w_xfer) w_next = S_HDR_LO;
      end
      S_HDR_LO: begin
        rx_ready = 1'b1;
        if (w_xfer) w_next = w_hdr_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (w_xfer && (r_bcnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        wr_en  = 1'b1;
        w_next = w_last ? S_DONE : S_DATA;
      end
      S_DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
        if (start) w_next = S_HDR_HI;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) w_next = S_HDR_HI;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Write address/data are captured on the 4th byte so they are already stable
  // throughout WRITE and simply hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_idx     <= '0;
      r_bcnt    <= '0;
      r_asm     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_idx  <= '0;
            r_bcnt <= '0;
          end
        end
        S_HDR_HI: begin
          if (w_xfer) r_count[15:8] <= rx_byte;
        end
        S_HDR_LO: begin
          if (w_xfer) r_count[7:0] <= rx_byte;
        end
        S_DATA: begin
          if (w_xfer) begin
            r_asm  <= w_word;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_wr_addr <= BASE_ADDR + {14'd0, r_idx, 2'b00};
              r_wr_data <= w_word;
            end
          end
        end
        S_WRITE: begin
          r_idx <= w_idx_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: a stream-level model predicts the writes and
// status of each load; writes are captured at the DUT boundary and compared.
`timescale 1ns/1ps
module tb_ins_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        done;
  logic        err;

  int total = 0;
  int bad = 0;

  ins_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  stim[$];
  logic [63:0] exp_w[$];
  bit          exp_err;
  logic [63:0] wq[$];
  int          rr_bad = 0;
  int          last_wr_cyc = 0;
  int          done_cyc = 0;
  int          last_xfer_cyc = 0;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back({wr_addr, wr_data});
      last_wr_cyc = cyc;
    end
    if (wr_en && rx_ready) rr_bad++;
    if (done && !prev_done) done_cyc = cyc;
    prev_done = done;
  end

  // Stream-level reference: header gives N, then each 4 bytes form one big-endian word.
  task automatic model();
    int n;
    n = int'({stim[0], stim[1]});
    exp_w.delete();
    exp_err = (n == 0) || (n > MAXW);
    if (!exp_err)
      for (int k = 0; k < n; k++)
        exp_w.push_back({BASE + 32'(4 * k),
                         stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]});
  endtask

  task automatic make_prog(input int n);
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    for (int k = 0; k < 4 * n; k++) stim.push_back(8'($urandom));
  endtask

  // Entered and left at posedge+1. gap: 0 = always valid, 1 = alternate, 2 = random.
  task automatic send(input int gap, output bit ok);
    int i;
    int c;
    i = 0;
    c = 0;
    while (i < stim.size() && c < 4 * stim.size() + 100) begin
      case (gap)
        0:       rx_valid = 1'b1;
        1:       rx_valid = (c % 2) == 1;
        default: rx_valid = $urandom_range(0, 3) != 0;
      endcase
      rx_byte = rx_valid ? stim[i] : 8'($urandom);
      @(negedge clk);
      if (rx_valid && rx_ready) begin
        i++;
        last_xfer_cyc = cyc;
      end
      c++;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    ok = (i == stim.size());
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (done || err) ok = 1'b1;
    end
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (core_hold !== 1'b1) begin bad++; $display("FAIL rst_core_hold got=%b exp=1", core_hold); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rst_rx_ready got=%b exp=0", rx_ready); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    total++; if (wr_addr !== 32'h0) begin bad++; $display("FAIL rst_wr_addr got=%h exp=0", wr_addr); end
    total++; if (wr_data !== 32'h0) begin bad++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
    total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL rst_done_err got=%b exp=00", {done, err}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    bit ok;
    bit ok2;
    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    model();
    wq.delete();
    pulse_start();
    send(0, ok);
    wait_end(ok2);
    total++; if (!(ok && ok2)) begin bad++; $display("FAIL normal_timeout got=%b%b exp=11", ok, ok2); end
    total++; if (wq.size() != 2) begin bad++; $display("FAIL normal_count got=%0d exp=2", wq.size()); end
    for (int k = 0; k < 2 && k < wq.size(); k++) begin
      total++;
      if (wq[k] !== exp_w[k]) begin bad++; $display("FAIL normal_write[%0d] got=%h exp=%h", k, wq[k], exp_w[k]); end
    end
    total++; if (exp_w[1] !== 64'h0000_0004_AC08_0000) begin bad++; $display("FAIL normal_model got=%h exp=0000_0004_AC08_0000", exp_w[1]); end
    total++; if (last_wr_cyc - last_xfer_cyc != 1) begin bad++; $display("FAIL byte_to_wr_latency got=%0d exp=1", last_wr_cyc - last_xfer_cyc); end
    total++; if (done_cyc - last_wr_cyc != 1) begin bad++; $display("FAIL wr_to_done_latency got=%0d exp=1", done_cyc - last_wr_cyc); end
    total++; if ({done, core_hold, err} !== 3'b100) begin bad++; $display("FAIL normal_status got=%b exp=100", {done, core_hold, err}); end
  endtask

  task automatic test_gaps();
    bit ok;
    bit ok2;
    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    model();
    wq.delete();
    rr_bad = 0;
    pulse_start();
    send(1, ok);
    wait_end(ok2);
    total++; if (!(ok && ok2)) begin bad++; $display("FAIL gaps_timeout got=%b%b exp=11", ok, ok2); end
    total++; if (wq.size() != exp_w.size()) begin bad++; $display("FAIL gaps_count got=%0d exp=%0d", wq.size(), exp_w.size()); end
    for (int k = 0; k < exp_w.size() && k < wq.size(); k++) begin
      total++;
      if (wq[k] !== exp_w[k]) begin bad++; $display("FAIL gaps_write[%0d] got=%h exp=%h", k, wq[k], exp_w[k]); end
    end
    total++; if (rr_bad != 0) begin bad++; $display("FAIL ready_in_write got=%0d exp=0", rr_bad); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL gaps_done got=%b exp=1", done); end
  endtask

  task automatic test_zero_hdr();
    bit ok;
    bit ok2;
    stim = {8'h00, 8'h00};
    model();
    wq.delete();
    pulse_start();
    send(0, ok);
    wait_end(ok2);
    total++; if (!(ok && ok2)) begin bad++; $display("FAIL zero_timeout got=%b%b exp=11", ok, ok2); end
    total++; if ({err, core_hold, done} !== {exp_err, 1'b1, 1'b0}) begin bad++; $display("FAIL zero_status got=%b exp=%b10", {err, core_hold, done}, exp_err); end
    total++; if (wq.size() != 0) begin bad++; $display("FAIL zero_writes got=%0d exp=0", wq.size()); end
    pulse_start();
    @(negedge clk);
    total++; if ({err, rx_ready} !== 2'b01) begin bad++; $display("FAIL zero_restart got=%b exp=01", {err, rx_ready}); end
    @(posedge clk); #1;
    rst = 1'b1; #1 rst = 1'b0;
  endtask

  task automatic test_oversize();
    bit ok;
    bit ok2;
    stim = {8'h01, 8'h01};
    model();
    wq.delete();
    pulse_start();
    send(0, ok);
    wait_end(ok2);
    total++; if (!(ok && ok2)) begin bad++; $display("FAIL over_timeout got=%b%b exp=11", ok, ok2); end
    total++; if ({err, done} !== {exp_err, 1'b0}) begin bad++; $display("FAIL over_err got=%b exp=%b0", {err, done}, exp_err); end
    make_prog(256);
    model();
    wq.delete();
    pulse_start();
    send(2, ok);
    wait_end(ok2);
    total++; if (!(ok && ok2)) begin bad++; $display("FAIL max_timeout got=%b%b exp=11", ok, ok2); end
    total++; if (wq.size() != 256) begin bad++; $display("FAIL max_count got=%0d exp=256", wq.size()); end
    for (int k = 0; k < exp_w.size() && k < wq.size(); k++) begin
      total++;
      if (wq[k] !== exp_w[k]) begin bad++; $display("FAIL max_write[%0d] got=%h exp=%h", k, wq[k], exp_w[k]); end
    end
    total++; if (wr_addr !== BASE + 32'h3FC) begin bad++; $display("FAIL max_last_addr got=%h exp=%h", wr_addr, BASE + 32'h3FC); end
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL max_done got=%b exp=10", {done, err}); end
  endtask

  task automatic test_random();
    bit ok;
    bit ok2;
    for (int it = 0; it < 4; it++) begin
      make_prog($urandom_range(1, 8));
      model();
      wq.delete();
      pulse_start();
      send(2, ok);
      wait_end(ok2);
      total++; if (!(ok && ok2)) begin bad++; $display("FAIL rand_timeout it=%0d got=%b%b exp=11", it, ok, ok2); end
      total++; if (wq.size() != exp_w.size()) begin bad++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, wq.size(), exp_w.size()); end
      for (int k = 0; k < exp_w.size() && k < wq.size(); k++) begin
        total++;
        if (wq[k] !== exp_w[k]) begin bad++; $display("FAIL rand_write it=%0d [%0d] got=%h exp=%h", it, k, wq[k], exp_w[k]); end
      end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL rand_done it=%0d got=%b exp=1", it, done); end
    end
  endtask

  task automatic test_reload();
    bit ok;
    bit ok2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    total++; if ({done, core_hold, rx_ready} !== 3'b011) begin bad++; $display("FAIL reload_status got=%b exp=011", {done, core_hold, rx_ready}); end
    @(posedge clk); #1;
    make_prog(3);
    model();
    wq.delete();
    send(0, ok);
    wait_end(ok2);
    total++; if (!(ok && ok2)) begin bad++; $display("FAIL reload_timeout got=%b%b exp=11", ok, ok2); end
    total++; if (wq.size() != 3) begin bad++; $display("FAIL reload_count got=%0d exp=3", wq.size()); end
    for (int k = 0; k < exp_w.size() && k < wq.size(); k++) begin
      total++;
      if (wq[k] !== exp_w[k]) begin bad++; $display("FAIL reload_write[%0d] got=%h exp=%h", k, wq[k], exp_w[k]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    stim = {8'h00, 8'h01, 8'hAA, 8'hBB};
    pulse_start();
    send(0, ok);
    total++; if (!ok || rx_ready !== 1'b1) begin bad++; $display("FAIL mid_setup got=%b%b exp=11", ok, rx_ready); end
    #2 rst = 1'b1;
    #1;
    total++; if ({rx_ready, core_hold, wr_en, done, err} !== 5'b01000) begin bad++; $display("FAIL mid_ctrl got=%b exp=01000", {rx_ready, core_hold, wr_en, done, err}); end
    total++; if ({wr_addr, wr_data} !== 64'h0) begin bad++; $display("FAIL mid_bus got=%h exp=0", {wr_addr, wr_data}); end
    @(negedge clk) rst = 1'b0;
    wq.delete();
    rx_valid = 1'b1;
    repeat (20) begin
      rx_byte = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    total++; if (wq.size() != 0) begin bad++; $display("FAIL mid_no_write got=%0d exp=0", wq.size()); end
    total++; if ({rx_ready, core_hold} !== 2'b01) begin bad++; $display("FAIL mid_idle got=%b exp=01", {rx_ready, core_hold}); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_gaps();
    test_zero_hdr();
    test_oversize();
    test_random();
    test_reload();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ins_loader.md
INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first program word.
REQ-002 Parameter MAX_WORDS, default 256, largest legal program length in words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE, ERR.
REQ-006 rx_valid  input  1  upstream byte available.
REQ-007 rx_byte  input  8  upstream byte.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready.
REQ-009 wr_en  output  1  one-cycle write strobe to instruction memory.
REQ-010 wr_addr  output  32  instruction-memory byte address of the write.
REQ-011 wr_data  output  32  instruction word to write.
REQ-012 core_hold  output  1  holds the datapath PC at reset while 1.
REQ-013 done  output  1  program loaded; core released.
REQ-014 err  output  1  illegal header received.

Function
REQ-015 The SHALL be an FSM with states IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR.
REQ-016 The stream format SHALL be a 16-bit word count N (high byte first), followed by N words of 4 bytes each, most significant byte first.
REQ-017 rx_ready SHALL be 1 only in HDR_HI, HDR_LO and DATA; it SHALL be 0 in all other states.
REQ-018 IDLE/DONE/ERR with start=1 SHALL go to HDR_HI next cycle, clearing done, err, the word index and the byte counter.
REQ-019 HDR_HI SHALL store the byte as count[15:8] on transfer and go to HDR_LO; HDR_LO SHALL store count[7:0] on transfer.
REQ-020 On the HDR_LO transfer, N==0 or N>MAX_WORDS SHALL go to ERR; otherwise the next state SHALL be DATA.
REQ-021 DATA SHALL shift each transferred byte into a 32-bit assembly register (new byte into bits [7:0], previous contents shifted left 8).
REQ-022 DATA SHALL count transfers with a 2-bit counter; on the 4th transfer the counter SHALL wrap to 0 and the next state SHALL be WRITE.
REQ-023 Cycles with rx_valid=0 SHALL leave all state, counters and the assembly register unchanged.
REQ-024 WRITE SHALL last exactly one cycle with wr_en=1, wr_addr=BASE_ADDR+4*idx (32-bit, wraps modulo 2^32) and wr_data=the assembled word.
REQ-025 At the end of WRITE, idx SHALL increment; if idx+1==N the next state SHALL be DONE, otherwise DATA.
REQ-026 wr_en SHALL be 0 outside WRITE; wr_addr/wr_data SHALL hold their last values.
REQ-027 core_hold SHALL be 0 only in DONE.
REQ-028 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-029 start while in HDR_HI..WRITE SHALL be ignored.
REQ-030 Latency from the 4th byte transfer to wr_en SHALL be exactly 1 cycle; from the last wr_en to done=1 SHALL be exactly 1 cycle.

Reset
REQ-031 rst=1 SHALL immediately, without a clock edge, force state=IDLE, idx=0, byte counter=0, count=0, assembly register=0.
REQ-032 During and after reset, the outputs SHALL be: core_hold=1, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0.
REQ-033 Reset asserted mid-load SHALL abandon the load; no wr_en SHALL be issued afterwards until a new start.

Verification
REQ-034 The bench SHALL cover a normal load: start; bytes 00 02 20 08 00 05 AC 08 00 00 with rx_valid always 1 -> wr_en twice: (addr 0, data 2008_0005), then (addr 4, data AC08_0000); done=1 and core_hold=0 one cycle after the second write.
REQ-035 The bench SHALL cover gaps: the same stream with rx_valid=0 on alternate cycles -> identical writes and data; rx_ready never 1 in WRITE.
REQ-036 The bench SHALL cover a zero header: bytes 00 00 -> ERR, err=1, core_hold=1, no wr_en; then start -> err=0, state HDR_HI.
REQ-037 The bench SHALL cover an oversized header with MAX_WORDS=256: header 01 01 -> err=1; header 01 00 -> accepted, 256 writes, last addr BASE_ADDR+0x3FC.
REQ-038 The bench SHALL cover reset mid-word: rst asserted between 2nd and 3rd data byte, asynchronous to clk -> outputs at reset values within the same cycle; no further wr_en.
REQ-039 The bench SHALL cover a reload: start asserted in DONE -> done=0 and core_hold=1 on the next cycle, then a second program overwrites from BASE_ADDR.
